// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Reads entries from a byte FIFO with a 1-cycle registered read latency and packs
// PACK consecutive entries into one wide word on a valid/ready output. A flush
// drains in-flight reads and emits whatever partial word remains, marked last.
module fifo_word_packer #(
   parameter int DATA_W = 8,
   parameter int PACK   = 4,
   localparam int CW    = $clog2(PACK + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   output logic                   fifo_rd,
   input  logic [DATA_W-1:0]      fifo_data,
   input  logic                   flush,
   output logic [PACK*DATA_W-1:0] out_data,
   output logic [CW-1:0]          out_count,
   output logic                   out_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   flush_done
);

   localparam int            CW1        = CW + 1;
   localparam logic [CW-1:0] C_PACK     = CW'(PACK);
   localparam logic [CW-1:0] C_PACKM1   = CW'(PACK - 1);
   localparam logic [CW:0]   C_OCC_FULL = CW1'(PACK);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_WAIT} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [DATA_W-1:0]       r_asm [PACK];
   logic [CW-1:0]           r_cnt;
   logic                    r_rd_d;
   logic [PACK*DATA_W-1:0]  r_out_data;
   logic [CW-1:0]           r_out_count;
   logic                    r_out_last;
   logic                    r_out_valid;

   logic                    w_out_free;
   logic                    w_complete;
   logic [CW:0]             w_occ;
   logic                    w_rd_ok;
   logic                    w_load_full;
   logic                    w_drain_go;
   logic                    w_flush_emit;
   logic                    w_accept;
   logic [PACK*DATA_W-1:0]  w_full_word;
   logic [PACK*DATA_W-1:0]  w_part_word;

   assign w_out_free   = !r_out_valid || out_ready;
   assign w_accept     = r_out_valid && out_ready;
   assign w_complete   = ((r_cnt == C_PACKM1) && r_rd_d) || (r_cnt == C_PACK);
   // Entries already captured plus the one still arriving from the FIFO.
   assign w_occ        = {1'b0, r_cnt} + {{CW{1'b0}}, r_rd_d};
   // The second term keeps 1 entry/cycle: the word completing now frees lane 0
   // in time for the entry requested this cycle.
   assign w_rd_ok      = (w_occ < C_OCC_FULL) ||
                         ((w_occ == C_OCC_FULL) && (r_cnt == C_PACKM1) && r_rd_d && w_out_free);
   assign fifo_rd      = rst && (r_state == S_RUN) && !flush && !fifo_empty && w_rd_ok;
   assign w_load_full  = (r_state == S_RUN) && w_complete && w_out_free;
   assign w_drain_go   = (r_state == S_DRAIN) && !r_rd_d && w_out_free;
   assign w_flush_emit = w_drain_go && (r_cnt != '0);

   // Lane views of the assembly register: the full word folds in the entry landing
   // this cycle; the partial word zeroes lanes that were never filled.
   generate
      for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
         assign w_full_word[gi*DATA_W +: DATA_W] =
            (r_rd_d && (r_cnt == CW'(gi))) ? fifo_data : r_asm[gi];
         assign w_part_word[gi*DATA_W +: DATA_W] =
            (CW'(gi) < r_cnt) ? r_asm[gi] : '0;
      end
   endgenerate

   // Next-state and flush_done pulse; flush_done is combinational so it coincides
   // with the accept of the flush word.
   always_comb begin
      w_state_next = r_state;
      flush_done   = 1'b0;
      case (r_state)
         S_RUN: begin
            if (flush) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_drain_go) begin
               if (r_cnt != '0) begin
                  w_state_next = S_WAIT;
               end else begin
                  flush_done   = 1'b1;
                  w_state_next = S_RUN;
               end
            end
         end
         S_WAIT: begin
            if (w_accept) begin
               flush_done   = 1'b1;
               w_state_next = S_RUN;
            end
         end
         default: w_state_next = S_RUN;
      endcase
   end

   // State register, read-latency tracking and lane counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_RUN;
         r_rd_d  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_rd_d  <= fifo_rd;
         if (w_load_full || ((r_state == S_WAIT) && w_accept))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CW'(r_rd_d);
      end
   end

   // Capture the entry returned by the FIFO into the lane it belongs to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PACK; i++) r_asm[i] <= '0;
      end else begin
         for (int i = 0; i < PACK; i++)
            if (r_rd_d && (r_cnt == CW'(i))) r_asm[i] <= fifo_data;
      end
   end

   // Output slot: load a full word, or the flush word, or retire an accepted word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_data  <= '0;
         r_out_count <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_load_full) begin
         r_out_data  <= w_full_word;
         r_out_count <= C_PACK;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b1;
      end else if (w_flush_emit) begin
         r_out_data  <= w_part_word;
         r_out_count <= r_cnt;
         r_out_last  <= 1'b1;
         r_out_valid <= 1'b1;
      end else if (w_accept) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_count = r_out_count;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a behavioural FIFO with registered read data feeds the
// packer; expected words are queued as bytes are written and compared against the
// words the packer hands over on accepted handshakes.
module tb_fifo_word_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd;
   logic [7:0]  fifo_data = 8'h00;
   logic        flush;
   logic [31:0] out_data;
   logic [2:0]  out_count;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        flush_done;

   fifo_word_packer #(.DATA_W(8), .PACK(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .flush      (flush),
      .out_data   (out_data),
      .out_count  (out_count),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .flush_done (flush_done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural FIFO: pointers owned by one process each, data registered on read.
   logic [7:0] fifo_mem [0:255];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       empty_force = 1'b0;
   assign fifo_empty = (wr_ptr == rd_ptr) || empty_force;

   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_data <= fifo_mem[rd_ptr[7:0]];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation: accepted words {flush_done, last, count, data} and event counters.
   logic [36:0] obs_mem [0:63];
   int obs_wr = 0;
   int rd_count = 0;
   int cur_run = 0;
   int last_run = 0;
   int rd_viol = 0;
   int fd_count = 0;
   int fd_cyc = -1;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         obs_mem[obs_wr[5:0]] <= {flush_done, out_last, out_count, out_data};
         obs_wr <= obs_wr + 1;
      end
      if (fifo_rd) begin
         rd_count <= rd_count + 1;
         cur_run  <= cur_run + 1;
      end else begin
         if (cur_run > 0) last_run <= cur_run;
         cur_run <= 0;
      end
      if (fifo_rd && fifo_empty) rd_viol <= rd_viol + 1;
      if (flush_done) begin
         fd_count <= fd_count + 1;
         fd_cyc   <= cyc;
      end
   end

   // Reference packing model driven alongside the stimulus.
   logic [36:0] exp_q [$];
   logic [31:0] acc = '0;
   int          acc_n = 0;
   int          obs_rd = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
      acc[acc_n*8 +: 8] = b;
      acc_n = acc_n + 1;
      if (acc_n == 4) begin
         exp_q.push_back({1'b0, 1'b0, 3'd4, acc});
         acc   = '0;
         acc_n = 0;
      end
   endtask

   task automatic do_flush(output int at_cyc);
      flush  = 1'b1;
      at_cyc = cyc;
      if (acc_n > 0) exp_q.push_back({1'b1, 1'b1, 3'(acc_n), acc});
      acc   = '0;
      acc_n = 0;
      tick(1);
      flush = 1'b0;
   endtask

   // Fetch the next observed word (bounded wait) and the next expected word.
   task automatic next_pair(output logic [36:0] e, output logic [36:0] o, output bit ok);
      int budget = 200;
      ok = 1'b1;
      e  = '0;
      o  = '0;
      while (obs_wr <= obs_rd && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      #1;
      if (obs_wr <= obs_rd) ok = 1'b0;
      else begin
         o = obs_mem[obs_rd[5:0]];
         obs_rd = obs_rd + 1;
      end
      if (exp_q.size() == 0) ok = 1'b0;
      else e = exp_q.pop_front();
   endtask

   task automatic test_reset;
      tick(3);
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
      vectors++;
      if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h, expected 0", out_data); end
      vectors++;
      if (out_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", out_count); end
      vectors++;
      if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b, expected 0", out_last); end
      vectors++;
      if (flush_done !== 1'b0) begin miscompares++; $display("FAIL reset_flush_done: got %b, expected 0", flush_done); end
      vectors++;
      if (fifo_rd !== 1'b0) begin miscompares++; $display("FAIL reset_fifo_rd: got %b, expected 0", fifo_rd); end
      rst = 1'b1;
      tick(2);
      $display("reset: outputs checked");
   endtask

   task automatic test_stream;
      logic [36:0] e, o;
      bit ok;
      int rd0 = rd_count;
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      for (int w = 0; w < 2; w++) begin
         next_pair(e, o, ok);
         vectors++;
         if (!ok || o !== e) begin miscompares++; $display("FAIL stream_word%0d: got %h, expected %h", w, o, e); end
         else $display("stream: word %0d = %h", w, o[31:0]);
      end
      tick(5);
      vectors++;
      if (rd_count - rd0 !== 8) begin miscompares++; $display("FAIL stream_reads: got %0d, expected 8", rd_count - rd0); end
      vectors++;
      if (last_run !== 8) begin miscompares++; $display("FAIL stream_rd_run: got %0d consecutive, expected 8", last_run); end
      vectors++;
      if (obs_wr !== obs_rd) begin miscompares++; $display("FAIL stream_extra: got %0d extra words, expected 0", obs_wr - obs_rd); end
   endtask

   task automatic test_backpressure;
      logic [36:0] e, o;
      bit ok;
      int rd0 = rd_count;
      out_ready = 1'b0;
      for (int i = 0; i < 12; i++) push_byte(8'(8'h20 + i));
      tick(20);
      vectors++;
      if (rd_count - rd0 !== 8) begin miscompares++; $display("FAIL bp_reads_stalled: got %0d, expected 8", rd_count - rd0); end
      vectors++;
      if (fifo_rd !== 1'b0) begin miscompares++; $display("FAIL bp_fifo_rd: got %b, expected 0", fifo_rd); end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h23222120) begin
         miscompares++; $display("FAIL bp_held_word: got valid=%b data=%h, expected valid=1 data=23222120", out_valid, out_data);
      end
      out_ready = 1'b1;
      for (int w = 0; w < 3; w++) begin
         next_pair(e, o, ok);
         vectors++;
         if (!ok || o !== e) begin miscompares++; $display("FAIL bp_word%0d: got %h, expected %h", w, o, e); end
         else $display("backpressure: word %0d = %h", w, o[31:0]);
      end
      tick(5);
      vectors++;
      if (rd_count - rd0 !== 12) begin miscompares++; $display("FAIL bp_reads_total: got %0d, expected 12", rd_count - rd0); end
   endtask

   task automatic test_empty_guard;
      logic [36:0] e, o;
      bit ok;
      int v0 = rd_viol;
      for (int i = 0; i < 8; i++) push_byte(8'(8'h30 + i));
      for (int c = 0; c < 40; c++) begin
         empty_force = ~empty_force;
         tick(1);
      end
      empty_force = 1'b0;
      for (int w = 0; w < 2; w++) begin
         next_pair(e, o, ok);
         vectors++;
         if (!ok || o !== e) begin miscompares++; $display("FAIL guard_word%0d: got %h, expected %h", w, o, e); end
         else $display("empty_guard: word %0d = %h", w, o[31:0]);
      end
      vectors++;
      if (rd_viol - v0 !== 0) begin miscompares++; $display("FAIL guard_rd_while_empty: got %0d, expected 0", rd_viol - v0); end
   endtask

   task automatic test_flush_partial;
      logic [36:0] e, o;
      bit ok;
      int fc;
      int fd0 = fd_count;
      push_byte(8'hAA);
      push_byte(8'hBB);
      push_byte(8'hCC);
      tick(8);
      do_flush(fc);
      next_pair(e, o, ok);
      vectors++;
      if (!ok || o !== e) begin miscompares++; $display("FAIL flush_partial_word: got %h, expected %h", o, e); end
      else $display("flush_partial: word = %h count=%0d last=%b", o[31:0], o[34:32], o[35]);
      tick(4);
      vectors++;
      if (fd_count - fd0 !== 1) begin miscompares++; $display("FAIL flush_partial_done: got %0d pulses, expected 1", fd_count - fd0); end
   endtask

   task automatic test_flush_empty;
      int fc;
      int fd0 = fd_count;
      int ow0 = obs_wr;
      tick(2);
      do_flush(fc);
      tick(5);
      vectors++;
      if (fd_cyc !== fc + 1) begin miscompares++; $display("FAIL flush_empty_timing: got cycle %0d, expected %0d", fd_cyc, fc + 1); end
      vectors++;
      if (fd_count - fd0 !== 1) begin miscompares++; $display("FAIL flush_empty_pulses: got %0d, expected 1", fd_count - fd0); end
      vectors++;
      if (obs_wr !== ow0) begin miscompares++; $display("FAIL flush_empty_word: got %0d words, expected 0", obs_wr - ow0); end
      $display("flush_empty: flush_done at cycle %0d", fd_cyc);
   endtask

   task automatic test_reset_midword;
      logic [36:0] e, o;
      bit ok;
      push_byte(8'h55);
      push_byte(8'h66);
      tick(6);
      rst   = 1'b0;
      acc   = '0;
      acc_n = 0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 3'd0 || out_last !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got valid=%b data=%h count=%0d last=%b, expected all 0", out_valid, out_data, out_count, out_last);
      end
      for (int i = 0; i < 4; i++) push_byte(8'(8'h11 + i));
      @(negedge clk);
      vectors++;
      if (fifo_rd !== 1'b0) begin miscompares++; $display("FAIL midreset_fifo_rd: got %b, expected 0", fifo_rd); end
      tick(1);
      rst = 1'b1;
      next_pair(e, o, ok);
      vectors++;
      if (!ok || o !== e) begin miscompares++; $display("FAIL midreset_word: got %h, expected %h", o, e); end
      else $display("reset_midword: word = %h", o[31:0]);
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_empty_guard();
      test_flush_partial();
      test_flush_empty();
      test_reset_midword();
      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
